// File: rtl/buffer_read_tx.sv
// D4H buffer-read transmit engine: walks the 256-byte page buffer and shifts bytes out MSB-first on SO.
// Optional macro DUMMY_BYTE_EN inserts eight dummy sck cycles between address and data phases.
module buffer_read_tx (
  input  logic       sck,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic [7:0] buf_out,
  output logic [7:0] rd_addr,
  output logic       en_read_buf,
  output logic       so,
  output logic       so_oe,
  output logic       rd_wrap
);

`ifdef DUMMY_BYTE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DUMMY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;
`endif

  state_t     r_state;
  logic [7:0] r_rd_addr;
  logic [7:0] r_shreg;
  logic [2:0] r_bit_cnt;
  logic       r_en_read_buf;
  logic       r_rd_wrap;
`ifdef DUMMY_BYTE_EN
  logic [2:0] r_dummy_cnt;
`endif

  // Deasserting CS# aborts the transfer exactly like a reset
  logic w_arst_n;
  assign w_arst_n = rst_n & ~cs_n;

  function automatic logic addr_wraps(input logic [7:0] addr);
    return (addr == 8'hFF);
  endfunction

  // Transfer FSM: address/byte fetch, bit shifting and wrap tracking on falling sck
  always_ff @(negedge sck or negedge w_arst_n) begin
    if (!w_arst_n) begin
      r_state       <= ST_IDLE;
      r_rd_addr     <= 8'd0;
      r_shreg       <= 8'd0;
      r_bit_cnt     <= 3'd0;
      r_en_read_buf <= 1'b0;
      r_rd_wrap     <= 1'b0;
`ifdef DUMMY_BYTE_EN
      r_dummy_cnt   <= 3'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rd_addr <= start_addr;
            r_bit_cnt <= 3'd0;
            r_rd_wrap <= 1'b0;
`ifdef DUMMY_BYTE_EN
            r_dummy_cnt   <= 3'd7;
            r_state       <= ST_DUMMY;
            r_en_read_buf <= 1'b0;
`else
            r_state       <= ST_LOAD;
            r_en_read_buf <= 1'b1;
`endif
          end else begin
            r_state       <= ST_IDLE;
            r_en_read_buf <= 1'b0;
          end
        end
`ifdef DUMMY_BYTE_EN
        ST_DUMMY: begin
          if (r_dummy_cnt == 3'd0) begin
            r_state       <= ST_LOAD;
            r_en_read_buf <= 1'b1;
          end else begin
            r_dummy_cnt   <= r_dummy_cnt - 3'd1;
          end
        end
`endif
        ST_LOAD: begin
          r_shreg   <= buf_out;
          r_rd_addr <= r_rd_addr + 8'd1;
          r_bit_cnt <= 3'd7;
          r_state   <= ST_SHIFT;
          if (addr_wraps(r_rd_addr)) begin
            r_rd_wrap <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // Last bit of a byte reloads immediately so the stream stays gapless
          if (r_bit_cnt != 3'd0) begin
            r_shreg   <= {r_shreg[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 3'd1;
          end else begin
            r_shreg   <= buf_out;
            r_rd_addr <= r_rd_addr + 8'd1;
            r_bit_cnt <= 3'd7;
            if (addr_wraps(r_rd_addr)) begin
              r_rd_wrap <= 1'b1;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_en_read_buf <= 1'b0;
        end
      endcase
    end
  end

  // so_oe must fall in the same delta as CS#, so it is decoded directly from cs_n
  assign so_oe       = (r_state == ST_SHIFT) && !cs_n;
  assign so          = so_oe & r_shreg[7];
  assign rd_addr     = r_rd_addr;
  assign en_read_buf = r_en_read_buf;
  assign rd_wrap     = r_rd_wrap;

endmodule
